// File: rtl/tx_scheduler.sv
// Round-robin arbiter sharing one Ethernet TX serializer between NUM_REQ requesters.
// Optional per-requester grant / timeout statistics when TX_SCHED_STATS_EN is defined.
module tx_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int IFG_CYCLES     = 48,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [31:0]            tx_data,
    output logic [2:0]             tx_src,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   err_timeout
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]  grant_count,
    output logic [7:0]             timeout_count
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        SEND      = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t             state_r;
    logic [PTR_W-1:0]   rr_ptr_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;

    logic [NUM_REQ-1:0] rot_s;
    logic [PTR_W:0]     sum_s;
    logic [PTR_W:0]     nxt_s;
    logic [PTR_W-1:0]   cand_s;
    logic [PTR_W-1:0]   win_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic               hit_s;
    logic               win_found_s;
    logic [31:0]        words_s [NUM_REQ];

    // Unpack requester words into an array indexed by requester number.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            words_s[k] = req_data[32*k +: 32];
        end
    end

    // Round-robin pick: rotate valids so bit 0 is rr_ptr, take the first set bit.
    always_comb begin
        rot_s       = NUM_REQ'({req_valid, req_valid} >> rr_ptr_r);
        sum_s       = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        win_s       = '0;
        win_found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_s       = {1'b0, rr_ptr_r} + (PTR_W + 1)'(k);
            cand_s      = (sum_s >= NUM_REQ_W) ? PTR_W'(sum_s - NUM_REQ_W) : PTR_W'(sum_s);
            hit_s       = rot_s[k] & ~win_found_s;
            win_s       = hit_s ? cand_s : win_s;
            win_found_s = win_found_s | hit_s;
        end
        nxt_s      = {1'b0, win_s} + (PTR_W + 1)'(1);
        next_ptr_s = (nxt_s >= NUM_REQ_W) ? '0 : PTR_W'(nxt_s);
    end

    // Main sequencer: grant, start pulse, busy/done handshake with timeout, inter-frame gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            to_cnt_r    <= '0;
            gap_cnt_r   <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 32'h0000_0000;
            tx_src      <= 3'd0;
            err_timeout <= 1'b0;
        end else begin
            req_ready   <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        tx_data   <= words_s[win_s];
                        tx_src    <= 3'(win_s);
                        req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                        rr_ptr_r  <= next_ptr_s;
                        state_r   <= START;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    to_cnt_r <= '0;
                    state_r  <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A done without any busy is a (very short) completed frame.
                    if (tx_done) begin
                        to_cnt_r <= '0;
                        state_r  <= GAP;
                    end else if (tx_busy) begin
                        to_cnt_r <= '0;
                        state_r  <= SEND;
                    end else if (to_cnt_r >= TO_LAST) begin
                        to_cnt_r    <= '0;
                        err_timeout <= 1'b1;
                        state_r     <= GAP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        to_cnt_r <= '0;
                        state_r  <= GAP;
                    end else if (to_cnt_r >= TO_LAST) begin
                        to_cnt_r    <= '0;
                        err_timeout <= 1'b1;
                        state_r     <= GAP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                GAP: begin
                    // The gap is measured from the moment the line actually goes quiet.
                    if (tx_busy) begin
                        gap_cnt_r <= gap_cnt_r;
                    end else if (gap_cnt_r >= GAP_LAST) begin
                        gap_cnt_r <= '0;
                        state_r   <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    to_cnt_r  <= '0;
                    gap_cnt_r <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef TX_SCHED_STATS_EN
    // Saturating statistics, bumped one clock after the corresponding pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count   <= '0;
            timeout_count <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (grant_count[16*i +: 16] != 16'hFFFF)) begin
                    grant_count[16*i +: 16] <= grant_count[16*i +: 16] + 16'd1;
                end
            end
            if (err_timeout && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: scoreboard of expected grants, serializer driven inline.
module tb_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [63:0] req_data = 64'd0;
    logic [1:0]  req_ready;
    logic        tx_start;
    logic [31:0] tx_data;
    logic [2:0]  tx_src;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic        err_timeout;
`ifdef TX_SCHED_STATS_EN
    logic [31:0] grant_count;
    logic [7:0]  timeout_count;
`endif

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cyc = 0;

    tx_scheduler #(.NUM_REQ(2), .IFG_CYCLES(48), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_src(tx_src),
        .tx_busy(tx_busy), .tx_done(tx_done), .err_timeout(err_timeout)
`ifdef TX_SCHED_STATS_EN
        , .grant_count(grant_count), .timeout_count(timeout_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int bound);
        int n = 0;
        while (tx_start !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_seen"}, {63'd0, tx_start}, 64'd1);
    endtask

    task automatic wait_ready(input string tag, input int bound, input logic [1:0] exp);
        int n = 0;
        while (req_ready === 2'b00 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {62'd0, req_ready}, {62'd0, exp});
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        chk({tag, "_sb_avail"}, {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_src"}, {61'd0, tx_src}, {61'd0, e.src});
            chk({tag, "_data"}, {32'd0, tx_data}, {32'd0, e.data});
        end
    endtask

    task automatic serve(input int busy_clks);
        tx_busy = 1'b1;
        repeat (busy_clks) @(negedge clk);
        tx_busy  = 1'b0;
        tx_done  = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   n;
        int   errs;
        logic seen;

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {25'd0, req_ready, tx_start, tx_data, tx_src, err_timeout}, 64'd0);
        rst_n = 1'b1;

        // Single request from requester 0.
        req_data  = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        req_valid = 2'b01;
        sb.push_back({3'd0, 32'hDEAD_BEEF});
        wait_ready("t1", 10, 2'b01);
        chk("t1_start_before_ready", {63'd0, tx_start}, 64'd0);
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_start_latency", {63'd0, tx_start}, 64'd1);
        check_frame("t1");
        @(negedge clk);
        chk("t1_start_width", {63'd0, tx_start}, 64'd0);
        chk("t1_ready_width", {62'd0, req_ready}, 64'd0);
        serve(20);
        chk("t1_data_hold", {32'd0, tx_data}, {32'd0, 32'hDEAD_BEEF});

        // Both requesters continuously valid: alternating grants with full gap.
        do_reset();
        req_data  = {32'hB1B1_0002, 32'hA0A0_0001};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(((i % 2) == 0) ? {3'd0, 32'hA0A0_0001} : {3'd1, 32'hB1B1_0002});
        end
        for (int i = 0; i < 4; i++) begin
            wait_start($sformatf("t2_%0d", i), 200);
            if (i > 0) chk($sformatf("t2_gap_%0d", i), {63'd0, (cyc - done_cyc >= 49)}, 64'd1);
            check_frame($sformatf("t2_%0d", i));
            serve(20);
        end
        req_valid = 2'b00;

        // Serializer never answers: timeout then the next pending word is granted.
        req_data[31:0] = 32'h1111_0001;
        req_valid      = 2'b01;
        sb.push_back({3'd0, 32'h1111_0001});
        wait_ready("t3", 100, 2'b01);
        req_data[31:0] = 32'h1111_0002;
        sb.push_back({3'd0, 32'h1111_0002});
        wait_start("t3a", 5);
        check_frame("t3a");
        n = 0;
        while (err_timeout !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_timeout_cycles", 64'(n), 64'd4096);
        @(negedge clk);
        chk("t3_err_width", {63'd0, err_timeout}, 64'd0);
        wait_start("t3b", 100);
        check_frame("t3b");
        req_valid = 2'b00;

        // Long busy with no done: SEND must not time out within 100 clocks.
        tx_busy = 1'b1;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (err_timeout) errs++;
        end
        chk("t4_no_timeout", 64'(errs), 64'd0);
        tx_busy  = 1'b0;
        tx_done  = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        tx_done = 1'b0;
        req_data[63:32] = 32'h2222_0003;
        req_valid       = 2'b10;
        sb.push_back({3'd1, 32'h2222_0003});
        wait_start("t4", 100);
        chk("t4_gap", {63'd0, (cyc - done_cyc >= 49)}, 64'd1);
        check_frame("t4");
        req_valid = 2'b00;
        serve(5);

        // Reset in the middle of SEND abandons the frame asynchronously.
        req_data[31:0] = 32'h3333_0004;
        req_valid      = 2'b01;
        sb.push_back({3'd0, 32'h3333_0004});
        wait_ready("t5", 100, 2'b01);
        req_valid = 2'b00;
        wait_start("t5", 5);
        check_frame("t5");
        tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", {25'd0, req_ready, tx_start, tx_data, tx_src, err_timeout}, 64'd0);
        tx_busy   = 1'b0;
        req_data  = {32'h4444_0006, 32'h4444_0005};
        req_valid = 2'b11;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | tx_start;
        end
        chk("t5_no_start_in_reset", {63'd0, seen}, 64'd0);
        rst_n = 1'b1;
        sb.push_back({3'd0, 32'h4444_0005});
        wait_start("t5_after_both", 10);
        check_frame("t5_after_both");
        rst_n     = 1'b0;
        req_valid = 2'b10;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back({3'd1, 32'h4444_0006});
        wait_start("t5_after_one", 10);
        check_frame("t5_after_one");
        req_valid = 2'b00;
        serve(3);

`ifdef TX_SCHED_STATS_EN
        // Five grants to requester 1, then one timeout on requester 0.
        do_reset();
        req_data  = {32'h5555_0001, 32'h6666_0001};
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            sb.push_back({3'd1, 32'h5555_0001});
            wait_start($sformatf("t6_%0d", i), 100);
            check_frame($sformatf("t6_%0d", i));
            serve(3);
        end
        req_valid = 2'b01;
        sb.push_back({3'd0, 32'h6666_0001});
        wait_start("t6_to", 100);
        check_frame("t6_to");
        req_valid = 2'b00;
        n = 0;
        while (err_timeout !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_timeout_seen", {63'd0, err_timeout}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_grant_count1", {48'd0, grant_count[31:16]}, 64'd5);
        chk("t6_grant_count0", {48'd0, grant_count[15:0]}, 64'd1);
        chk("t6_timeout_count", {56'd0, timeout_count}, 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
